// File: rtl/shadow_stack_ctrl_pkg.sv
// Shared types and constants for the shadow stack sequencer.
// States, alarm codes and parameter defaults.
package shadow_stack_ctrl_pkg;

  localparam int DEF_ADDR_W      = 32;
  localparam int DEF_MAX_ENTRIES = 127;
  localparam int DEF_RET_OFFSET  = 8;
  localparam int DEF_CNT_W       = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PUSH   = 3'd1;
  localparam logic [2:0] ST_SETTLE = 3'd2;
  localparam logic [2:0] ST_POP    = 3'd3;
  localparam logic [2:0] ST_CMP    = 3'd4;
  localparam logic [2:0] ST_ALARM  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    PUSH   = ST_PUSH,
    SETTLE = ST_SETTLE,
    POP    = ST_POP,
    CMP    = ST_CMP,
    ALARM  = ST_ALARM
  } state_t;

  localparam logic [1:0] ALM_NONE      = 2'b00;
  localparam logic [1:0] ALM_MISMATCH  = 2'b01;
  localparam logic [1:0] ALM_UNDERFLOW = 2'b10;
  localparam logic [1:0] ALM_OVERFLOW  = 2'b11;

endpackage

// File: rtl/shadow_viol_counter.sv
// Saturating violation counter.
// Sync active-low clear, one-cycle increment strobe.
module shadow_viol_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  // count strobes, stick at all-ones
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/shadow_stack_ctrl.sv
// Call/return sequencer for the 128-entry shadow stack.
// Pushes return addresses, pops and compares on return.
module shadow_stack_ctrl
  import shadow_stack_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int MAX_ENTRIES = DEF_MAX_ENTRIES,
  parameter int RET_OFFSET  = DEF_RET_OFFSET,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              call_valid,
  input  logic [ADDR_W-1:0] call_pc,
  input  logic              ret_valid,
  input  logic [ADDR_W-1:0] ret_target,
  output logic              req_ready,
  input  logic              alarm_clr,
  output logic              alarm,
  output logic [1:0]        alarm_code,
  output logic [7:0]        depth,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic              stk_reset,
  output logic              stk_en,
  output logic              stk_push_pop,
  output logic [ADDR_W-1:0] stk_data_in,
  input  logic [ADDR_W-1:0] stk_data_out,
  input  logic              stk_violation
);

  state_t            state_q;
  state_t            state_d;
  logic [7:0]        depth_q;
  logic [ADDR_W-1:0] ret_q;
  logic              alarm_q;
  logic [1:0]        code_q;

  logic              call_acc;
  logic              ret_acc;
  logic              cmp_fail;
  logic              push_ld;
  logic              pop_ld;
  logic              en_d;
  logic              dep_inc;
  logic              dep_dec;
  logic              raise;
  logic [1:0]        raise_code;

  assign stk_reset = ~reset;
  assign req_ready = (state_q == IDLE);
  assign ret_acc   = ret_valid & req_ready;
  assign call_acc  = call_valid & req_ready & ~ret_valid;
  assign cmp_fail  = (state_q == CMP) && (stk_data_out != ret_q);
  assign depth     = depth_q;

  // mismatch shows in the compare cycle, before ALARM registers it
  assign alarm      = alarm_q | cmp_fail;
  assign alarm_code = alarm_q  ? code_q :
                      cmp_fail ? ALM_MISMATCH : ALM_NONE;

  // state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and per-cycle control strobes
  always_comb begin
    state_d    = state_q;
    push_ld    = 1'b0;
    pop_ld     = 1'b0;
    en_d       = 1'b0;
    dep_inc    = 1'b0;
    dep_dec    = 1'b0;
    raise      = 1'b0;
    raise_code = ALM_NONE;
    case (state_q)
      IDLE: begin
        if (stk_violation) begin
          raise      = 1'b1;
          raise_code = ALM_OVERFLOW;
        end else if (call_acc) begin
          if (depth_q == 8'(MAX_ENTRIES)) begin
            raise      = 1'b1;
            raise_code = ALM_OVERFLOW;
          end else begin
            push_ld = 1'b1;
            en_d    = 1'b1;
            state_d = PUSH;
          end
        end else if (ret_acc) begin
          if (depth_q == 8'd0) begin
            raise      = 1'b1;
            raise_code = ALM_UNDERFLOW;
          end else begin
            pop_ld  = 1'b1;
            en_d    = 1'b1;
            state_d = POP;
          end
        end
      end
      PUSH: begin
        dep_inc = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: state_d = IDLE;
      POP: begin
        dep_dec = 1'b1;
        state_d = CMP;
      end
      CMP: begin
        if (cmp_fail) begin
          raise      = 1'b1;
          raise_code = ALM_MISMATCH;
        end else begin
          state_d = IDLE;
        end
      end
      ALARM: begin
        if (alarm_clr) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (raise) state_d = ALARM;
  end

  // registered stack command lines and latched return target
  always_ff @(posedge clk) begin
    if (!reset) begin
      stk_en       <= 1'b0;
      stk_push_pop <= 1'b0;
      stk_data_in  <= '0;
      ret_q        <= '0;
    end else begin
      stk_en <= en_d;
      if (push_ld) begin
        stk_push_pop <= 1'b1;
        stk_data_in  <= call_pc + ADDR_W'(RET_OFFSET);
      end
      if (pop_ld) begin
        stk_push_pop <= 1'b0;
        ret_q        <= ret_target;
      end
    end
  end

  // occupancy tracking
  always_ff @(posedge clk) begin
    if (!reset) begin
      depth_q <= 8'd0;
    end else if (dep_inc) begin
      depth_q <= depth_q + 8'd1;
    end else if (dep_dec) begin
      depth_q <= depth_q - 8'd1;
    end
  end

  // sticky alarm keeps the first cause until cleared
  always_ff @(posedge clk) begin
    if (!reset) begin
      alarm_q <= 1'b0;
      code_q  <= ALM_NONE;
    end else if (raise) begin
      alarm_q <= 1'b1;
      code_q  <= raise_code;
    end else if ((state_q == ALARM) && alarm_clr) begin
      alarm_q <= 1'b0;
      code_q  <= ALM_NONE;
    end
  end

  shadow_viol_counter #(
    .CNT_W (CNT_W)
  ) u_viol_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (raise),
    .cnt   (viol_cnt)
  );

endmodule

// File: tb/tb_shadow_stack_ctrl.sv
// Self-checking bench for shadow_stack_ctrl.
// Behavioural stack model plus stack-command scoreboard.
module tb_shadow_stack_ctrl;

  typedef struct packed {
    logic        push;
    logic [31:0] data;
  } op_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        call_valid;
  logic [31:0] call_pc;
  logic        ret_valid;
  logic [31:0] ret_target;
  logic        req_ready;
  logic        alarm_clr;
  logic        alarm;
  logic [1:0]  alarm_code;
  logic [7:0]  depth;
  logic [15:0] viol_cnt;
  logic        stk_reset;
  logic        stk_en;
  logic        stk_push_pop;
  logic [31:0] stk_data_in;
  logic [31:0] stk_data_out;
  logic        stk_violation;

  int n_checks = 0;
  int n_fail   = 0;
  int en_count = 0;

  op_t         exp_q[$];
  logic [31:0] mdl_stack[$];
  logic [31:0] mem [0:127];
  int          sp = 0;

  always #5 clk = ~clk;

  shadow_stack_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .call_valid    (call_valid),
    .call_pc       (call_pc),
    .ret_valid     (ret_valid),
    .ret_target    (ret_target),
    .req_ready     (req_ready),
    .alarm_clr     (alarm_clr),
    .alarm         (alarm),
    .alarm_code    (alarm_code),
    .depth         (depth),
    .viol_cnt      (viol_cnt),
    .stk_reset     (stk_reset),
    .stk_en        (stk_en),
    .stk_push_pop  (stk_push_pop),
    .stk_data_in   (stk_data_in),
    .stk_data_out  (stk_data_out),
    .stk_violation (stk_violation)
  );

  // behavioural 128-deep stack with registered output
  always @(posedge clk) begin
    if (stk_reset) begin
      sp <= 0;
      stk_data_out <= '0;
    end else if (stk_en) begin
      if (stk_push_pop) begin
        mem[sp[6:0]] <= stk_data_in;
        sp <= sp + 1;
      end else begin
        stk_data_out <= mem[(sp - 1) & 127];
        sp <= sp - 1;
      end
    end
  end

  // every stack command must match the next expected one
  always @(negedge clk) begin
    if (stk_en === 1'b1) begin
      op_t e;
      en_count++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stray_stk_en got pp=%0b data=%h exp=none",
                 stk_push_pop, stk_data_in);
      end else begin
        e = exp_q.pop_front();
        if (stk_push_pop !== e.push ||
            (e.push && stk_data_in !== e.data)) begin
          n_fail++;
          $display("FAIL stk_cmd got pp=%0b data=%h exp pp=%0b data=%h",
                   stk_push_pop, stk_data_in, e.push, e.data);
        end
      end
    end
  end

  task automatic call_once(input logic [31:0] pc, input bit do_push);
    bit got = 0;
    @(posedge clk); #1;
    call_valid = 1'b1;
    call_pc    = pc;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL call_accept got=timeout exp=ready");
    end else if (do_push) begin
      exp_q.push_back({1'b1, pc + 32'd8});
      mdl_stack.push_back(pc + 32'd8);
    end
    @(posedge clk); #1;
    call_valid = 1'b0;
  endtask

  task automatic ret_once(input logic [31:0] tgt, input bit do_pop);
    bit got = 0;
    @(posedge clk); #1;
    ret_valid  = 1'b1;
    ret_target = tgt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL ret_accept got=timeout exp=ready");
    end else if (do_pop) begin
      exp_q.push_back({1'b0, 32'h0});
      void'(mdl_stack.pop_back());
    end
    @(posedge clk); #1;
    ret_valid = 1'b0;
  endtask

  task automatic clear_alarm();
    @(posedge clk); #1;
    alarm_clr = 1'b1;
    @(posedge clk); #1;
    alarm_clr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    call_valid = 0; call_pc = '0;
    ret_valid = 0; ret_target = '0;
    alarm_clr = 0; stk_violation = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (stk_reset !== 1'b1) begin
      n_fail++; $display("FAIL rst_stk_reset got=%b exp=1", stk_reset);
    end
    n_checks++;
    if ({alarm, alarm_code, depth, viol_cnt} !== 27'd0) begin
      n_fail++;
      $display("FAIL rst_status got alarm=%b code=%b depth=%0d viol=%0d exp=0",
               alarm, alarm_code, depth, viol_cnt);
    end
    n_checks++;
    if ({stk_en, stk_push_pop, stk_data_in} !== 34'd0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_stk_lines got en=%b pp=%b din=%h rdy=%b exp=0,0,0,1",
               stk_en, stk_push_pop, stk_data_in, req_ready);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (stk_reset !== 1'b0) begin
      n_fail++; $display("FAIL rel_stk_reset got=%b exp=0", stk_reset);
    end
  endtask

  task automatic test_call_latency();
    call_once(32'h0000_1000, 1);
    @(negedge clk);
    n_checks++;
    if (stk_en !== 1'b1 || stk_push_pop !== 1'b1 ||
        stk_data_in !== 32'h0000_1008 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL call_t1 got en=%b pp=%b din=%h rdy=%b exp=1,1,00001008,0",
               stk_en, stk_push_pop, stk_data_in, req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (stk_en !== 1'b0 || depth !== 8'd1 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL call_t2 got en=%b depth=%0d rdy=%b exp=0,1,0",
               stk_en, depth, req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL call_t3_ready got=%b exp=1", req_ready);
    end
  endtask

  task automatic test_ret_match();
    ret_once(32'h0000_1008, 1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (alarm !== 1'b0 || depth !== 8'd0) begin
      n_fail++;
      $display("FAIL ret_ok_t2 got alarm=%b depth=%0d exp=0,0", alarm, depth);
    end
    @(negedge clk);
    n_checks++;
    if (req_ready !== 1'b1 || viol_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL ret_ok_t3 got rdy=%b viol=%0d exp=1,0", req_ready, viol_cnt);
    end
  endtask

  task automatic test_mismatch();
    call_once(32'h0000_2000, 1);
    ret_once(32'h0000_3000, 1);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (alarm !== 1'b1 || alarm_code !== 2'b01 || depth !== 8'd0 ||
        req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mism_t2 got alarm=%b code=%b depth=%0d rdy=%b exp=1,01,0,0",
               alarm, alarm_code, depth, req_ready);
    end
    @(negedge clk);
    n_checks++;
    if (viol_cnt !== 16'd1 || alarm !== 1'b1 || alarm_code !== 2'b01) begin
      n_fail++;
      $display("FAIL mism_t3 got viol=%0d alarm=%b code=%b exp=1,1,01",
               viol_cnt, alarm, alarm_code);
    end
    clear_alarm();
    @(negedge clk);
    n_checks++;
    if (alarm !== 1'b0 || alarm_code !== 2'b00 || req_ready !== 1'b1 ||
        viol_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL mism_clr got alarm=%b code=%b rdy=%b viol=%0d exp=0,00,1,1",
               alarm, alarm_code, req_ready, viol_cnt);
    end
  endtask

  task automatic test_underflow();
    ret_once(32'h0000_4000, 0);
    @(negedge clk);
    n_checks++;
    if (alarm !== 1'b1 || alarm_code !== 2'b10 || viol_cnt !== 16'd2 ||
        depth !== 8'd0) begin
      n_fail++;
      $display("FAIL underflow got alarm=%b code=%b viol=%0d depth=%0d exp=1,10,2,0",
               alarm, alarm_code, viol_cnt, depth);
    end
    clear_alarm();
  endtask

  task automatic test_overflow();
    logic [31:0] t;
    for (int i = 0; i < 127; i++) begin
      call_once(32'h0001_0000 + 32'(i * 16), 1);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (depth !== 8'd127) begin
      n_fail++; $display("FAIL full_depth got=%0d exp=127", depth);
    end
    call_once(32'h0000_9000, 0);
    @(negedge clk);
    n_checks++;
    if (alarm !== 1'b1 || alarm_code !== 2'b11 || depth !== 8'd127 ||
        viol_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL overflow got alarm=%b code=%b depth=%0d viol=%0d exp=1,11,127,3",
               alarm, alarm_code, depth, viol_cnt);
    end
    clear_alarm();
    for (int i = 0; i < 126; i++) begin
      t = mdl_stack[$];
      ret_once(t, 1);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (depth !== 8'd1 || alarm !== 1'b0 || viol_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL drain got depth=%0d alarm=%b viol=%0d exp=1,0,3",
               depth, alarm, viol_cnt);
    end
  endtask

  task automatic test_stk_violation();
    @(posedge clk); #1;
    stk_violation = 1'b1;
    @(posedge clk); #1;
    stk_violation = 1'b0;
    @(negedge clk);
    n_checks++;
    if (alarm !== 1'b1 || alarm_code !== 2'b11 || viol_cnt !== 16'd4 ||
        depth !== 8'd1) begin
      n_fail++;
      $display("FAIL stk_viol got alarm=%b code=%b viol=%0d depth=%0d exp=1,11,4,1",
               alarm, alarm_code, viol_cnt, depth);
    end
    clear_alarm();
  endtask

  task automatic test_back_to_back();
    bit got = 0;
    logic [31:0] v = mdl_stack[$];
    @(posedge clk); #1;
    call_valid = 1'b1; call_pc = 32'h0000_5000;
    ret_valid  = 1'b1; ret_target = v;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    exp_q.push_back({1'b0, 32'h0});
    void'(mdl_stack.pop_back());
    @(posedge clk); #1;
    ret_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (!got || stk_en !== 1'b1 || stk_push_pop !== 1'b0) begin
      n_fail++;
      $display("FAIL simul_ret_first got acc=%b en=%b pp=%b exp=1,1,0",
               got, stk_en, stk_push_pop);
    end
    got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready) begin got = 1; break; end
    end
    n_checks++;
    if (!got) begin
      n_fail++; $display("FAIL held_call got=timeout exp=ready");
    end
    exp_q.push_back({1'b1, 32'h0000_5008});
    mdl_stack.push_back(32'h0000_5008);
    @(posedge clk); #1;
    call_valid = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (depth !== 8'd1 || alarm !== 1'b0 || viol_cnt !== 16'd4) begin
      n_fail++;
      $display("FAIL simul_end got depth=%0d alarm=%b viol=%0d exp=1,0,4",
               depth, alarm, viol_cnt);
    end
  endtask

  task automatic test_reset_mid_pop();
    int en_before;
    logic [31:0] t = mdl_stack[$];
    ret_once(t, 1);
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (stk_reset !== 1'b1) begin
      n_fail++; $display("FAIL midrst_stk_reset got=%b exp=1", stk_reset);
    end
    mdl_stack.delete();
    @(negedge clk);
    n_checks++;
    if (depth !== 8'd0 || alarm !== 1'b0 || req_ready !== 1'b1 ||
        stk_en !== 1'b0 || viol_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL midrst_state got depth=%0d alarm=%b rdy=%b en=%b viol=%0d exp=0,0,1,0,0",
               depth, alarm, req_ready, stk_en, viol_cnt);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    en_before = en_count;
    repeat (6) @(negedge clk);
    n_checks++;
    if (en_count != en_before) begin
      n_fail++;
      $display("FAIL midrst_stray_en got=%0d exp=0", en_count - en_before);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_call_latency();
    test_ret_match();
    test_mismatch();
    test_underflow();
    test_overflow();
    test_stk_violation();
    test_back_to_back();
    test_reset_mid_pop();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
